// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: CS setup delay, TIP while counting clkgen sample pulses, CS hold delay, done/irq.
// Latency: go at edge N drives CS low from N+1 and TIP high from N+1+half; abort returns to IDLE on the next edge.
module spi_xfer_ctrl #(
  parameter int DIV_WIDTH = 16,  // must match spi_clkgen
  parameter int LEN_WIDTH = 7
) (
  input  logic                 sys_clk_i,
  input  logic                 rst_i,
  input  logic                 go_i,
  input  logic                 abort_i,
  input  logic [LEN_WIDTH-1:0] char_len_i,
  input  logic [DIV_WIDTH-1:0] divider_i,
  input  logic                 sample_i,
  input  logic                 shift_i,
  input  logic                 irq_en_i,
  input  logic                 irq_ack_i,
  output logic                 tip_o,
  output logic                 cs_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 irq_o,
  output logic [LEN_WIDTH-1:0] bit_cnt_o,
  output logic                 last_bit_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [LEN_WIDTH:0] CNT_ONE = (LEN_WIDTH+1)'(1);
  localparam logic [DIV_WIDTH-1:0] DLY_ONE = DIV_WIDTH'(1);

  state_t               state_q, state_d;
  logic [LEN_WIDTH:0]   len_q, len_d;
  logic [LEN_WIDTH:0]   cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] half_q, half_d;
  logic [DIV_WIDTH-1:0] dly_q, dly_d;
  logic                 irq_q, irq_d;

  logic [DIV_WIDTH-1:0] half_w;
  logic [LEN_WIDTH:0]   eff_len_w;
  logic [LEN_WIDTH:0]   cnt_inc_w;
  logic                 irq_set_w;
  logic                 unused_shift;

  // shift is consumed by the shift-register datapath directly, not here.
  assign unused_shift = shift_i;

  assign half_w    = (divider_i[DIV_WIDTH-1:1] == '0) ? DLY_ONE : {1'b0, divider_i[DIV_WIDTH-1:1]};
  assign eff_len_w = (char_len_i == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, char_len_i};
  assign cnt_inc_w = cnt_q + CNT_ONE;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      half_q  <= '0;
      dly_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      dly_q   <= dly_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    dly_d     = dly_q;
    irq_set_w = 1'b0;
    cs_o      = 1'b1;
    tip_o     = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_i && !abort_i) begin
          state_d = SETUP;
          len_d   = eff_len_w;
          half_d  = half_w;
          dly_d   = half_w - DLY_ONE;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        cs_o = 1'b0;
        if (abort_i)             state_d = IDLE;
        else if (dly_q == '0)    state_d = XFER;
        else                     dly_d   = dly_q - DLY_ONE;
      end
      XFER: begin
        cs_o  = 1'b0;
        tip_o = 1'b1;
        if (abort_i) begin
          state_d = IDLE;
        end else if (sample_i) begin
          cnt_d = cnt_inc_w;
          // Wide compare so a 2**LEN_WIDTH-bit transfer terminates when bit_cnt wraps to 0.
          if (cnt_inc_w == len_q) begin
            state_d = HOLD;
            dly_d   = half_q - DLY_ONE;
          end
        end
      end
      HOLD: begin
        cs_o = 1'b0;
        if (abort_i)             state_d = IDLE;
        else if (dly_q == '0)    state_d = DONE;
        else                     dly_d   = dly_q - DLY_ONE;
      end
      DONE: begin
        state_d = IDLE;
        if (!abort_i) begin
          done_o    = 1'b1;
          irq_set_w = irq_en_i;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new completion outranks an acknowledge arriving in the same cycle.
    irq_d = irq_set_w ? 1'b1 : (irq_ack_i ? 1'b0 : irq_q);
  end

  assign busy_o     = (state_q != IDLE);
  assign irq_o      = irq_q;
  assign bit_cnt_o  = cnt_q[LEN_WIDTH-1:0];
  assign last_bit_o = (state_q == XFER) && (cnt_q == len_q - CNT_ONE);

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: per-cycle vector table plus hand-written transfer sequences.
module tb_spi_xfer_ctrl;

  logic       sys_clk, rst, go, abort, sample, shift, irq_en, irq_ack;
  logic [6:0] char_len;
  logic [7:0] divider;
  logic       tip, cs, busy, done, irq, last_bit;
  logic [6:0] bit_cnt;

  spi_xfer_ctrl #(.DIV_WIDTH(8), .LEN_WIDTH(7)) dut (
    .sys_clk_i (sys_clk),
    .rst_i     (rst),
    .go_i      (go),
    .abort_i   (abort),
    .char_len_i(char_len),
    .divider_i (divider),
    .sample_i  (sample),
    .shift_i   (shift),
    .irq_en_i  (irq_en),
    .irq_ack_i (irq_ack),
    .tip_o     (tip),
    .cs_o      (cs),
    .busy_o    (busy),
    .done_o    (done),
    .irq_o     (irq),
    .bit_cnt_o (bit_cnt),
    .last_bit_o(last_bit)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       go, ab, smp;
    logic [6:0] len;
    logic [7:0] dv;
    logic       ien, iack;
    logic       cs, tip, bsy, dn, irq;
    logic [6:0] cnt;
    logic       lb;
  } vec_t;

  vec_t tbl [13];
  int   n_vec = 0;
  int   n_bad = 0;
  int   r_cf, r_setup, r_samp, r_hold, r_done, r_lberr, r_tmo;

  function automatic vec_t mk(input int g, input int a, input int s, input int l, input int d,
                              input int ie, input int ia, input int ecs, input int etip,
                              input int ebsy, input int edn, input int eirq, input int ecnt,
                              input int elb);
    vec_t v;
    v.go = g[0];     v.ab = a[0];     v.smp = s[0];
    v.len = l[6:0];  v.dv = d[7:0];   v.ien = ie[0]; v.iack = ia[0];
    v.cs = ecs[0];   v.tip = etip[0]; v.bsy = ebsy[0]; v.dn = edn[0];
    v.irq = eirq[0]; v.cnt = ecnt[6:0]; v.lb = elb[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Runs one transfer; samples are offered every per-th TIP cycle. ab_at >= 0 aborts
  // (together with a sample pulse) once that many samples have been accepted.
  task automatic run_xfer(input int len, input int dv, input int per, input int ab_at);
    int  xc;
    int  eff;
    bit  seen_tip;
    eff = (len == 0) ? 128 : len;
    xc = 0; seen_tip = 0;
    r_setup = 0; r_samp = 0; r_hold = 0; r_done = 0; r_lberr = 0; r_tmo = 1;
    go = 1'b1; char_len = 7'(len); divider = 8'(dv);
    tick();
    go = 1'b0;
    r_cf = int'(cs);
    for (int c = 0; c < 1000; c++) begin
      sample = 1'b0; abort = 1'b0;
      if (!busy) begin
        r_tmo = 0;
        break;
      end
      if (done) r_done++;
      if (last_bit && !tip) r_lberr++;
      if (tip) begin
        seen_tip = 1;
        if (last_bit !== (r_samp == eff - 1)) r_lberr++;
        if (ab_at >= 0 && r_samp == ab_at) begin
          abort = 1'b1; sample = 1'b1;
        end else if (xc % per == per - 1) begin
          sample = 1'b1; r_samp++;
        end
        xc++;
      end else if (!cs && !seen_tip) begin
        r_setup++;
      end else if (!cs) begin
        r_hold++;
      end
      tick();
    end
    sample = 1'b0; abort = 1'b0;
  endtask

  task automatic chk_xfer(input string t, input int setup_e, input int samp_e, input int hold_e,
                          input int done_e, input int cnt_e);
    chk({t, ".timeout"}, r_tmo, 0);
    chk({t, ".cs_after_go"}, r_cf, 0);
    chk({t, ".setup_cycles"}, r_setup, setup_e);
    chk({t, ".samples"}, r_samp, samp_e);
    chk({t, ".hold_cycles"}, r_hold, hold_e);
    chk({t, ".done_pulses"}, r_done, done_e);
    chk({t, ".last_bit_errs"}, r_lberr, 0);
    chk({t, ".bit_cnt"}, bit_cnt, cnt_e);
    chk({t, ".cs_end"}, cs, 1);
    chk({t, ".tip_end"}, tip, 0);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; abort = 1'b0; sample = 1'b0; shift = 1'b0;
    irq_en = 1'b0; irq_ack = 1'b0; char_len = '0; divider = '0;

    // Rows: inputs go,abort,sample,len,div,irq_en,irq_ack | expected cs,tip,busy,done,irq,bit_cnt,last_bit
    tbl[0]  = mk(1,0,0,3,4,1,0, 1,0,0,0,0,0,0);
    tbl[1]  = mk(1,0,1,5,8,1,0, 0,0,1,0,0,0,0);  // go and sample ignored in SETUP, len/div changes ignored
    tbl[2]  = mk(0,0,0,5,8,1,0, 0,0,1,0,0,0,0);
    tbl[3]  = mk(0,0,1,5,8,1,0, 0,1,1,0,0,0,0);
    tbl[4]  = mk(0,0,0,5,8,1,0, 0,1,1,0,0,1,0);
    tbl[5]  = mk(0,0,1,5,8,1,0, 0,1,1,0,0,1,0);
    tbl[6]  = mk(0,0,1,5,8,1,0, 0,1,1,0,0,2,1);
    tbl[7]  = mk(0,0,1,5,8,1,0, 0,0,1,0,0,3,0);  // HOLD ignores sample
    tbl[8]  = mk(0,0,0,5,8,1,0, 0,0,1,0,0,3,0);
    tbl[9]  = mk(0,0,0,5,8,1,1, 1,0,1,1,0,3,0);  // DONE with ack: set wins
    tbl[10] = mk(0,0,1,5,8,1,0, 1,0,0,0,1,3,0);
    tbl[11] = mk(0,0,0,5,8,1,1, 1,0,0,0,1,3,0);
    tbl[12] = mk(0,0,0,5,8,1,0, 1,0,0,0,0,3,0);

    #3;
    chk("reset.cs", cs, 1);
    chk("reset.tip", tip, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.irq", irq, 0);
    chk("reset.bit_cnt", bit_cnt, 0);
    chk("reset.last_bit", last_bit, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      go = tbl[i].go; abort = tbl[i].ab; sample = tbl[i].smp; char_len = tbl[i].len;
      divider = tbl[i].dv; irq_en = tbl[i].ien; irq_ack = tbl[i].iack;
      #1;
      chk($sformatf("row%0d.cs", i), cs, tbl[i].cs);
      chk($sformatf("row%0d.tip", i), tip, tbl[i].tip);
      chk($sformatf("row%0d.busy", i), busy, tbl[i].bsy);
      chk($sformatf("row%0d.done", i), done, tbl[i].dn);
      chk($sformatf("row%0d.irq", i), irq, tbl[i].irq);
      chk($sformatf("row%0d.bit_cnt", i), bit_cnt, tbl[i].cnt);
      chk($sformatf("row%0d.last_bit", i), last_bit, tbl[i].lb);
      tick();
    end
    go = 1'b0; abort = 1'b0; sample = 1'b0; irq_ack = 1'b0;

    irq_en = 1'b1;
    run_xfer(8, 4, 4, -1);
    chk_xfer("len8_div4", 2, 8, 2, 1, 8);
    chk("len8_div4.irq", irq, 1);

    // Async reset mid-XFER with irq pending.
    go = 1'b1; char_len = 7'd8; divider = 8'd4;
    tick(); go = 1'b0;
    tick(); tick();
    chk("arst.pre_tip", tip, 1);
    sample = 1'b1; tick(); sample = 1'b0;
    chk("arst.pre_cnt", bit_cnt, 1);
    rst = 1'b1;
    #2;
    chk("arst.cs", cs, 1);
    chk("arst.tip", tip, 0);
    chk("arst.busy", busy, 0);
    chk("arst.bit_cnt", bit_cnt, 0);
    chk("arst.irq", irq, 0);
    chk("arst.last_bit", last_bit, 0);
    #2 rst = 1'b0;
    tick();
    chk("arst.idle_after", busy, 0);

    irq_en = 1'b0;
    run_xfer(0, 2, 1, -1);
    chk_xfer("len128", 1, 128, 1, 1, 0);
    chk("len128.irq_off", irq, 0);

    run_xfer(5, 1, 2, -1);
    chk_xfer("div1", 1, 5, 1, 1, 5);

    irq_en = 1'b1;
    run_xfer(8, 4, 2, 3);
    chk_xfer("abort3", 2, 3, 0, 0, 3);
    chk("abort3.busy", busy, 0);
    chk("abort3.irq", irq, 0);

    run_xfer(4, 6, 1, 3);
    chk_xfer("abort_final", 3, 3, 0, 0, 3);
    chk("abort_final.irq", irq, 0);

    go = 1'b1; abort = 1'b1; tick();
    go = 1'b0; abort = 1'b0;
    chk("go_abort_idle.busy", busy, 0);
    chk("go_abort_idle.cs", cs, 1);
    tick();
    chk("go_abort_idle.busy2", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transfer sequencer for the SPI master. It accepts a start command from the register interface and asserts CS with a setup delay. It then raises TIP so spi_clkgen produces SCK, and counts spi_clkgen sample pulses until the programmed character length is reached. Finally it drops TIP, holds CS for a hold delay, releases CS and reports completion. It sits between the register block and spi_clkgen, and feeds the shift-register datapath with bit-position and last-bit information.

Parameters:
DIV_WIDTH, `DIV_WIDTH, width of divider input; must match spi_clkgen.
LEN_WIDTH, 7, width of char_len and bit_cnt; max character length is 2**LEN_WIDTH bits.

Ports:
sys_clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active high
go  input  1  start request, sampled only in IDLE
abort  input  1  terminate transfer immediately
char_len  input  LEN_WIDTH  bits per transfer; 0 means 2**LEN_WIDTH
divider  input  DIV_WIDTH  same value given to spi_clkgen; sets setup/hold length
sample  input  1  one-cycle pulse from spi_clkgen
shift  input  1  one-cycle pulse from spi_clkgen
irq_en  input  1  interrupt enable
irq_ack  input  1  clears irq
TIP  output  1  transfer in progress, to spi_clkgen
CS  output  1  chip select, active low, to spi_clkgen and pad
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse on normal completion
irq  output  1  sticky interrupt
bit_cnt  output  LEN_WIDTH  samples taken so far in current transfer
last_bit  output  1  high while bit_cnt == effective length - 1 in XFER

Behaviour:
- Reset (async, any state): state=IDLE, CS=1, TIP=0, busy=0, done=0, irq=0, bit_cnt=0, delay counter=0.
- half = divider>>1; when half==0, use 1. eff_len = char_len, or 2**LEN_WIDTH when char_len==0. Internal length compare is LEN_WIDTH+1 bits wide.
- States:
  - IDLE: go=1 and abort=0 -> SETUP. Latch char_len and half, clear bit_cnt, load delay counter. go in any other state is ignored.
  - SETUP: CS=0, TIP=0 for exactly half sys_clk cycles -> XFER.
  - XFER: CS=0, TIP=1. Each sample pulse increments bit_cnt. The sample pulse that makes the count equal eff_len moves to HOLD on the same edge. shift pulses are counted nowhere and only pass through to the datapath.
  - HOLD: TIP=0, CS=0 for exactly half cycles -> DONE.
  - DONE: CS=1, done=1 for one cycle; irq set if irq_en=1 -> IDLE.
- Latched char_len and half are used throughout the transfer; input changes mid-transfer have no effect.
- Latency: go seen at edge N -> CS=0 from N+1, TIP=1 from N+1+half.
- Sample and shift pulses are ignored outside XFER. bit_cnt holds its final value in IDLE until the next go.
- abort in SETUP/XFER/HOLD/DONE: next edge goes to IDLE with CS=1, TIP=0, no done, no irq. abort with go in IDLE: stay IDLE. abort beats the final sample.
- irq: sticky, set in DONE when irq_en=1, cleared by irq_ack. Set and ack in the same cycle: set wins.
- bit_cnt wraps to 0 only at eff_len = 2**LEN_WIDTH on the terminating sample; the compare uses the wide counter.

Test Plan:
- divider=4, char_len=8, stub sample every 4 cycles: CS low 1 cycle after go, TIP high 2 cycles later. After the 8th sample, TIP low and CS still low 2 cycles, then done=1 for 1 cycle, CS=1. bit_cnt=8.
- char_len=0, LEN_WIDTH=7: transfer ends on the 128th sample. Exactly 128 samples accepted; last_bit high only before the 128th.
- divider=1 (half=0): SETUP and HOLD each last exactly 1 cycle; transfer still completes.
- abort asserted after 3 samples of an 8-bit transfer: next cycle CS=1, TIP=0, busy=0, done never pulses, irq stays 0.
- irq_en=1, irq_ack held high in the DONE cycle: irq=1 after the edge. Ack one cycle later -> irq=0.
- go pulsed again while busy, plus sample pulses in IDLE: no effect on state, bit_cnt or CS. Async rst mid-XFER: outputs take reset values immediately, without waiting for a clock edge.
